// File: rtl/mvau_wseq_pkg.sv
// Shared types and constants for the MVAU weight-memory sequencer.
package mvau_wseq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wseq_state_e;

  // Entries in the read-data buffer between weight memory and datapath.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mvau_wmem_seq_if.sv
// Weight-memory read port plus weight-word stream toward the datapath.
// master = sequencer side, slave = memory/datapath side.
interface mvau_wmem_seq_if #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_ADDR_BW = 4
);

  logic [WMEM_ADDR_BW-1:0] wmem_addr;
  logic                    wmem_rd_en;
  logic [SIMD*TW-1:0]      wmem_in;
  logic [SIMD*TW-1:0]      wgt_out;
  logic                    wgt_valid;
  logic                    wgt_ready;
  logic                    wgt_last;

  modport master (
    output wmem_addr, wmem_rd_en, wgt_out, wgt_valid, wgt_last,
    input  wmem_in, wgt_ready
  );

  modport slave (
    input  wmem_addr, wmem_rd_en, wgt_out, wgt_valid, wgt_last,
    output wmem_in, wgt_ready
  );

endinterface

// File: rtl/mvau_wseq_skid.sv
// Two-entry buffer (data + last flag) holding weight words returned by
// memory until the datapath accepts them. Head entry is the output word.
module mvau_wseq_skid
  import mvau_wseq_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic          head_valid,
  output logic [1:0]    count
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } entry_t;

  entry_t     slot0_q, slot1_q, slot0_d, slot1_d, in_entry;
  logic [1:0] count_q, count_d;
  logic       do_pop, do_push;

  assign in_entry = '{data: push_data, last: push_last};

  // Next-state of the two slots; slot0 is always the head.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && !((count_q == 2'(FIFO_DEPTH)) && !do_pop);
    unique case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = in_entry;
        else                 slot1_d = in_entry;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = in_entry;
        end else begin
          slot0_d = slot1_q;
          slot1_d = in_entry;
        end
      end
      default: ;
    endcase
    if (flush) count_d = 2'd0;
  end

  // Slot and occupancy registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the slots are reset (not just the count) because the head drives wgt_out, which must read 0 after reset.
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_data  = slot0_q.data;
  assign head_last  = slot0_q.last;
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/mvau_wmem_seq.sv
// MVAU weight-memory sequencer: on start, reads WMEM_DEPTH words NUM_REPS
// times from a 1-cycle-latency memory and streams them with valid/ready.
// Optional feature: define MVAU_WSEQ_ABORT_EN to add an abort input.
module mvau_wmem_seq
  import mvau_wseq_pkg::*;
#(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NUM_REPS     = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic start,
`ifdef MVAU_WSEQ_ABORT_EN
  input  logic abort,
`endif
  output logic busy,
  output logic done,
  mvau_wmem_seq_if.master bus
);

  localparam int DW      = SIMD * TW;
  localparam int PASS_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;

  wseq_state_e             state_q, state_d;
  logic [WMEM_ADDR_BW-1:0] addr_q;
  logic [PASS_BW-1:0]      pass_q;
  logic                    inflight_q, inflight_last_q;
  logic                    done_q, done_d;
  logic                    abort_req, rd_en, rd_last, final_rd, pop;
  logic                    head_valid, head_last;
  logic [DW-1:0]           head_data;
  logic [1:0]              count;
  logic [2:0]              committed;

`ifdef MVAU_WSEQ_ABORT_EN
  assign abort_req = abort && (state_q != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Words buffered or on their way after this cycle's pop; a new read is
  // only issued when it is guaranteed a free slot.
  assign pop       = head_valid && bus.wgt_ready;
  assign committed = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_last   = (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
  assign rd_en     = (state_q == RUN) && !abort_req && (committed < 3'(FIFO_DEPTH));
  assign final_rd  = rd_en && rd_last && (pass_q == PASS_BW'(NUM_REPS - 1));

  // Next state and done pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (final_rd) state_d = DRAIN;
      DRAIN: begin
        if (!inflight_q && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_req) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  // State register and registered done pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Read address and pass counter; both return to 0 after the final read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q <= '0;
      pass_q <= '0;
    end else if (abort_req) begin
      addr_q <= '0;
      pass_q <= '0;
    end else if (rd_en) begin
      if (rd_last) begin
        addr_q <= '0;
        pass_q <= final_rd ? '0 : pass_q + 1'b1;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Tracks the read whose data arrives on wmem_in next cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && rd_last;
    end
  end

  mvau_wseq_skid #(.DW(DW)) u_skid (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .flush      (abort_req),
    .push       (inflight_q),
    .push_data  (bus.wmem_in),
    .push_last  (inflight_last_q),
    .pop        (pop),
    .head_data  (head_data),
    .head_last  (head_last),
    .head_valid (head_valid),
    .count      (count)
  );

  assign bus.wmem_addr  = addr_q;
  assign bus.wmem_rd_en = rd_en;
  assign bus.wgt_out    = head_data;
  assign bus.wgt_valid  = head_valid;
  assign bus.wgt_last   = head_valid && head_last;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_mvau_wmem_seq.sv
// Self-checking bench for mvau_wmem_seq: memory model, ready patterns and a
// word-sequence reference model checked every cycle by one monitor.
module tb_mvau_wmem_seq;

  localparam int SIMD         = 2;
  localparam int TW           = 1;
  localparam int WMEM_DEPTH   = 4;
  localparam int WMEM_ADDR_BW = 4;
  localparam int NUM_REPS     = 2;
  localparam int DW           = SIMD * TW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic aclk = 1'b0;
  logic aresetn, start, busy, done;
`ifdef MVAU_WSEQ_ABORT_EN
  logic abort;
`endif

  mvau_wmem_seq_if #(.SIMD(SIMD), .TW(TW), .WMEM_ADDR_BW(WMEM_ADDR_BW)) bus ();

  mvau_wmem_seq #(
    .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(WMEM_DEPTH),
    .WMEM_ADDR_BW(WMEM_ADDR_BW), .NUM_REPS(NUM_REPS)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (start),
`ifdef MVAU_WSEQ_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Weight memory content and 1-cycle read model.
  logic [DW-1:0] mem [WMEM_DEPTH];
  always @(posedge aclk) begin
    if (bus.wmem_rd_en && (int'(bus.wmem_addr) < WMEM_DEPTH))
      bus.wmem_in <= mem[int'(bus.wmem_addr)];
  end

  // Reference model state shared with the monitor.
  word_t         exp_q[$];
  int            addr_log[$];
  int            last_log[$];
  int            exp_addr, reads, xfers, total, seqs_done;
  bit            mon_en, done_due, prev_stall, fin;
  logic [DW-1:0] prev_out;
  logic          prev_last;
  word_t         w;

  // Ready patterns: 0 always high, 1 five-cycle stall after word 3,
  // 2 toggle, 3 random, 4 held by the test.
  int rdy_mode = 0;
  int stall_left = 0;
  bit stall_done = 0;
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0: bus.wgt_ready = 1'b1;
      1: begin
        if (stall_left > 0) begin
          bus.wgt_ready = 1'b0;
          stall_left--;
        end else if (xfers == 3 && !stall_done) begin
          bus.wgt_ready = 1'b0;
          stall_left = 4;
          stall_done = 1;
        end else begin
          bus.wgt_ready = 1'b1;
        end
      end
      2: bus.wgt_ready = ~bus.wgt_ready;
      3: bus.wgt_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: compares the stream, read addresses, done and buffering bound.
  always @(negedge aclk) begin
    if (mon_en) begin
      fin = 0;
      check("done", 64'(done), 64'(done_due));
      if (done_due) begin
        check("busy_at_done", 64'(busy), 64'(0));
        seqs_done++;
      end
      if (prev_stall) begin
        check("hold_valid", 64'(bus.wgt_valid), 64'(1));
        check("hold_out", 64'(bus.wgt_out), 64'(prev_out));
        check("hold_last", 64'(bus.wgt_last), 64'(prev_last));
      end
      if (bus.wgt_valid && bus.wgt_ready) begin
        check("word_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("wgt_out", 64'(bus.wgt_out), 64'(w.data));
          check("wgt_last", 64'(bus.wgt_last), 64'(w.last));
          xfers++;
          if (bus.wgt_last) last_log.push_back(xfers);
          fin = (xfers == total);
        end
      end
      if (bus.wmem_rd_en) begin
        check("rd_addr", 64'(bus.wmem_addr), 64'(exp_addr));
        addr_log.push_back(int'(bus.wmem_addr));
        exp_addr = (exp_addr + 1) % WMEM_DEPTH;
        reads++;
        check("rd_count", 64'(reads <= total), 64'(1));
      end
      if (!busy) begin
        check("idle_rd_en", 64'(bus.wmem_rd_en), 64'(0));
        check("idle_addr", 64'(bus.wmem_addr), 64'(0));
      end
      check("outstanding", 64'((reads - xfers) <= 2), 64'(1));
      prev_stall = bus.wgt_valid && !bus.wgt_ready;
      prev_out   = bus.wgt_out;
      prev_last  = bus.wgt_last;
      done_due   = fin;
    end
  end

  // Fresh memory image and expected word sequence for one start.
  task automatic prep_seq(input int mode);
    word_t e;
    for (int a = 0; a < WMEM_DEPTH; a++) mem[a] = DW'($urandom);
    exp_q.delete();
    addr_log.delete();
    last_log.delete();
    for (int r = 0; r < NUM_REPS; r++)
      for (int a = 0; a < WMEM_DEPTH; a++) begin
        e.data = mem[a];
        e.last = (a == WMEM_DEPTH - 1);
        exp_q.push_back(e);
      end
    total      = WMEM_DEPTH * NUM_REPS;
    reads      = 0;
    xfers      = 0;
    exp_addr   = 0;
    prev_stall = 0;
    done_due   = 0;
    stall_left = 0;
    stall_done = 0;
    rdy_mode   = mode;
    mon_en     = 1;
  endtask

  task automatic pulse_start();
    @(posedge aclk);
    #1 start = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    int cyc = 0;
    while (xfers < n && cyc < 200) begin
      @(posedge aclk);
      cyc++;
    end
    if (xfers < n) check("wait_xfers", 64'(xfers), 64'(n));
  endtask

  task automatic run_seq(input int mode, input bit latency_chk, input bit restart_mid);
    int seq0;
    int cyc = 0;
    prep_seq(mode);
    seq0 = seqs_done;
    pulse_start();
    if (latency_chk) begin
      @(negedge aclk);
      check("lat_busy", 64'(busy), 64'(1));
      check("lat_valid0", 64'(bus.wgt_valid), 64'(0));
      @(negedge aclk);
      check("lat_valid1", 64'(bus.wgt_valid), 64'(0));
      @(negedge aclk);
      check("lat_valid2", 64'(bus.wgt_valid), 64'(1));
    end
    while (seqs_done == seq0 && cyc < 300) begin
      @(posedge aclk);
      cyc++;
      if (restart_mid && cyc == 4) begin
        #1 start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
      end
    end
    repeat (4) @(posedge aclk);
    check("seq_done_count", 64'(seqs_done - seq0), 64'(1));
    check("seq_words", 64'(xfers), 64'(total));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_rd_en"}, 64'(bus.wmem_rd_en), 64'(0));
    check({tag, "_addr"}, 64'(bus.wmem_addr), 64'(0));
    check({tag, "_valid"}, 64'(bus.wgt_valid), 64'(0));
    check({tag, "_last"}, 64'(bus.wgt_last), 64'(0));
    check({tag, "_out"}, 64'(bus.wgt_out), 64'(0));
  endtask

  int lit_addrs[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0;
    start = 1'b0;
    bus.wgt_ready = 1'b0;
    mon_en = 0;
    seqs_done = 0;
`ifdef MVAU_WSEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_all_zero("reset");
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Basic run, ready high: latency, addresses, last flags, done timing.
    prep_seq(0);
    check("model_len", 64'(exp_q.size()), 64'(8));
    check("model_last", 64'({exp_q[0].last, exp_q[3].last, exp_q[7].last}), 64'(3'b011));
    run_seq(0, 1, 0);
    check("addr_log_len", 64'(addr_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < addr_log.size(); i++)
      check("addr_seq", 64'(addr_log[i]), 64'(lit_addrs[i]));
    check("last_log_len", 64'(last_log.size()), 64'(2));
    if (last_log.size() == 2) begin
      check("last_word_a", 64'(last_log[0]), 64'(4));
      check("last_word_b", 64'(last_log[1]), 64'(8));
    end

    // Five-cycle stall mid-pass.
    run_seq(1, 0, 0);
    // Start pulsed again while running.
    run_seq(0, 0, 1);
    // Ready toggling each cycle.
    run_seq(2, 0, 0);

    // Reset after word 3, then a clean sequence from address 0.
    prep_seq(0);
    pulse_start();
    wait_xfers(3);
    #1;
    mon_en = 0;
    aresetn = 1'b0;
    @(negedge aclk);
    check_all_zero("midreset");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    run_seq(0, 1, 0);

`ifdef MVAU_WSEQ_ABORT_EN
    // Abort after word 2.
    prep_seq(0);
    pulse_start();
    wait_xfers(2);
    #1;
    mon_en = 0;
    rdy_mode = 4;
    bus.wgt_ready = 1'b0;
    abort = 1'b1;
    @(posedge aclk);
    #1 abort = 1'b0;
    @(negedge aclk);
    check("abort_done", 64'(done), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_valid", 64'(bus.wgt_valid), 64'(0));
    check("abort_rd_en", 64'(bus.wmem_rd_en), 64'(0));
    @(negedge aclk);
    check("abort_done_pulse", 64'(done), 64'(0));
    run_seq(0, 0, 0);
`endif

    // Randomized ready with fresh memory contents.
    for (int k = 0; k < 4; k++) run_seq(3, 0, 0);

    repeat (3) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mvau_wmem_seq.md
MVAU_WMEM_SEQ -- requirements
Module: mvau_wmem_seq

Interface
REQ-001 SHALL have parameter SIMD, default 2, meaning input lanes per weight word.
REQ-002 SHALL have parameter TW, default 1, meaning bits per weight.
REQ-003 SHALL have parameter WMEM_DEPTH, default 4, meaning words per pass.
REQ-004 SHALL have parameter WMEM_ADDR_BW, default 4, meaning address width.
REQ-005 SHALL have parameter NUM_REPS, default 2, meaning full passes per start.
REQ-006 SHALL have port aclk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-007 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to begin NUM_REPS passes.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the sequence is complete.
REQ-011 SHALL have port wmem_addr, output, WMEM_ADDR_BW bits: weight memory read address.
REQ-012 SHALL have port wmem_rd_en, output, 1 bit: wmem_addr is a real read this cycle.
REQ-013 SHALL have port wmem_in, input, SIMD*TW bits: memory data, valid exactly 1 cycle after a wmem_rd_en cycle.
REQ-014 SHALL have port wgt_out, output, SIMD*TW bits: weight word to the datapath.
REQ-015 SHALL have port wgt_valid, output, 1 bit: wgt_out holds a valid word.
REQ-016 SHALL have port wgt_ready, input, 1 bit: consumer accepts the word.
REQ-017 SHALL have port wgt_last, output, 1 bit: wgt_out is address WMEM_DEPTH-1 of a pass.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-019 SHALL move IDLE->RUN on start; start in RUN or DRAIN SHALL be ignored.
REQ-020 SHALL transfer a word when wgt_valid&&wgt_ready; wgt_out/wgt_last SHALL hold stable while wgt_valid&&!wgt_ready.
REQ-021 SHALL buffer read data in a 2-entry FIFO and assert wmem_rd_en only in RUN when (occupancy + in-flight reads - pop this cycle) < 2.
REQ-022 SHALL push wmem_in into the FIFO on the cycle after each wmem_rd_en; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-023 SHALL increment wmem_addr after each issued read and wrap WMEM_DEPTH-1->0, incrementing the pass counter on wrap.
REQ-024 SHALL move RUN->DRAIN on the cycle the read of address WMEM_DEPTH-1 of pass NUM_REPS-1 is issued.
REQ-025 SHALL move DRAIN->IDLE and pulse done in the cycle after the last word transfers, FIFO empty, no read in flight.
REQ-026 SHALL, with wgt_ready held high, sustain one transfer per cycle; first wgt_valid SHALL be 2 cycles after start.
REQ-027 SHALL keep wmem_addr at 0 and wmem_rd_en low in IDLE.

Reset
REQ-028 SHALL on aresetn low: state IDLE, wmem_addr 0, pass counter 0, FIFO empty, in-flight cleared, busy/done/wmem_rd_en/wgt_valid/wgt_last 0, wgt_out 0.
REQ-029 SHALL discard all buffered and in-flight words on reset mid-sequence; no done pulse follows.

Configuration
REQ-030 SHALL, with MVAU_WSEQ_ABORT_EN defined, add input abort (1 bit): in RUN/DRAIN it flushes FIFO and in-flight, returns to IDLE next cycle, and pulses done; abort in IDLE is ignored.
REQ-031 SHALL, without MVAU_WSEQ_ABORT_EN, have no abort port; sequences end only by completion or reset.

Structure
REQ-032 SHALL place the state enum and FIFO depth constant (2) in package mvau_wseq_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module mvau_wseq_skid (data + last bit).

Verification
REQ-034 SHALL test WMEM_DEPTH=4, NUM_REPS=2, ready always 1: start -> addresses 0,1,2,3,0,1,2,3, 8 words, wgt_last on words 4 and 8, done one cycle after word 8.
REQ-035 SHALL test ready low for 5 cycles mid-pass: wgt_out stable, wmem_rd_en low once FIFO full, no word lost or duplicated.
REQ-036 SHALL test start during RUN: ignored, exactly 8 words, one done.
REQ-037 SHALL test aresetn low after word 3: all outputs 0 next edge; new start yields words from address 0.
REQ-038 SHALL test ready toggling every cycle: 8 words in order, occupancy never exceeds 2.
REQ-039 SHALL test, with MVAU_WSEQ_ABORT_EN, abort after word 2: IDLE next cycle, done pulse, wgt_valid 0.
